// File: rtl/mul24_sched.sv
// mul24_sched: shares one pipelined 24x24 multiplier between two ports.
// Optional perf counters: define MUL24_SCHED_PERF_EN.
module mul24_sched #(
    parameter int DATA_WIDH  = 24,
    parameter int MUL_LAT    = 3,
    parameter int RESP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*DATA_WIDH-1:0] req_a,
    input  logic [2*DATA_WIDH-1:0] req_b,
    input  logic [3:0]             req_mode,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [4*DATA_WIDH-1:0] resp_data,
    output logic                   mul_valid,
    output logic [1:0]             mul_mode,
    output logic [DATA_WIDH-1:0]   mul_a,
    output logic [DATA_WIDH-1:0]   mul_b,
    input  logic                   mul_res_valid,
    input  logic [2*DATA_WIDH-1:0] mul_res,
    output logic                   err
`ifdef MUL24_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_grant0,
    output logic [31:0]            perf_grant1,
    output logic [31:0]            perf_conflict
`endif
);
    localparam int RW = 2 * DATA_WIDH;
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(MUL_LAT + 1);

    logic [RW-1:0]      mem_q [2][RESP_DEPTH];
    logic [RW-1:0]      mem_d [2][RESP_DEPTH];
    logic [PW-1:0]      wr_q [2];
    logic [PW-1:0]      wr_d [2];
    logic [PW-1:0]      rd_q [2];
    logic [PW-1:0]      rd_d [2];
    logic [CW-1:0]      cnt_q [2];
    logic [CW-1:0]      cnt_d [2];
    logic [CW-1:0]      infl_q [2];
    logic [CW-1:0]      infl_d [2];
    logic [MUL_LAT-1:0] tv_q, tv_d;
    logic [MUL_LAT-1:0] to_q, to_d;
    logic               rr_q, rr_d;
    logic               err_q, err_d;
    logic [DW-1:0]      drain_q, drain_d;

    logic [CW-1:0]      credit [2];
    logic [1:0]         has_cr;
    logic [1:0]         elig, gnt;
    logic [1:0]         push, free, pop, full;
    logic [1:0]         mode_raw;
    logic               gsel, illegal;
    logic               tail_v, tail_o, stray, lost;

    // Credit check and round-robin grant; nothing is granted in reset
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            credit[i] = CW'(RESP_DEPTH) - cnt_q[i] - infl_q[i];
            has_cr[i] = (credit[i] != '0);
            elig[i]   = req_valid[i] & has_cr[i] & ~rst;
        end
        if (elig == 2'b11) begin
            gnt = rr_q ? 2'b10 : 2'b01;
        end else begin
            gnt = elig;
        end
        gsel     = gnt[1];
        mode_raw = gsel ? req_mode[3:2] : req_mode[1:0];
        illegal  = (|gnt) & (mode_raw == 2'b10);
    end

    assign req_ready = gnt;
    assign mul_valid = |gnt;
    assign mul_a = !mul_valid ? '0 :
                   gsel ? req_a[RW-1:DATA_WIDH] : req_a[DATA_WIDH-1:0];
    assign mul_b = !mul_valid ? '0 :
                   gsel ? req_b[RW-1:DATA_WIDH] : req_b[DATA_WIDH-1:0];
    assign mul_mode = (mul_valid & ~illegal) ? mode_raw : 2'b00;
    assign err = err_q;

    // FIFO heads are read straight from the storage registers
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            resp_valid[i] = (cnt_q[i] != '0) & ~rst;
            resp_data[i*RW +: RW] = mem_q[i][rd_q[i]];
        end
    end

    // Match the tag-pipe tail against the multiplier return
    always_comb begin
        tail_v = tv_q[MUL_LAT-1];
        tail_o = to_q[MUL_LAT-1];
        // stale returns just after reset belong to discarded ops
        stray  = mul_res_valid & ~tail_v & (drain_q == '0);
        lost   = tail_v & ~mul_res_valid;
        for (int i = 0; i < 2; i++) begin
            free[i] = tail_v & (tail_o == 1'(i));
            push[i] = free[i] & mul_res_valid;
            full[i] = (cnt_q[i] == CW'(RESP_DEPTH));
            pop[i]  = resp_valid[i] & resp_ready[i];
        end
    end

    // Next state: FIFOs, credits, tag pipe, arbiter pointer, error
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            wr_d[i] = wr_q[i];
            rd_d[i] = rd_q[i];
            if (push[i] & ~full[i]) begin
                mem_d[i][wr_q[i]] = mul_res;
                wr_d[i] = wr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_d[i] = rd_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i] & ~full[i])
                     - CW'(pop[i]);
            infl_d[i] = infl_q[i] + CW'(gnt[i]) - CW'(free[i]);
        end
        tv_d    = {tv_q[MUL_LAT-2:0], |gnt};
        to_d    = {to_q[MUL_LAT-2:0], gsel};
        rr_d    = (|gnt) ? ~gsel : rr_q;
        err_d   = err_q | illegal | stray | lost | (|(push & full));
        drain_d = (drain_q != '0) ? drain_q - DW'(1) : drain_q;
    end

    // Response storage needs no reset; validity lives in the counters
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_q[i]   <= '0;
                rd_q[i]   <= '0;
                cnt_q[i]  <= '0;
                infl_q[i] <= '0;
            end
            tv_q    <= '0;
            to_q    <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            drain_q <= DW'(MUL_LAT);
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_q[i]   <= wr_d[i];
                rd_q[i]   <= rd_d[i];
                cnt_q[i]  <= cnt_d[i];
                infl_q[i] <= infl_d[i];
            end
            tv_q    <= tv_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end
    end

`ifdef MUL24_SCHED_PERF_EN
    logic [31:0] pg0_q, pg0_d;
    logic [31:0] pg1_q, pg1_d;
    logic [31:0] pcf_q, pcf_d;
    logic        conflict;

    // Grant and contention counters, wrapping at 2^32
    always_comb begin
        conflict = ~rst & ((&req_valid) | (|(req_valid & ~has_cr)));
        pg0_d = pg0_q + 32'(gnt[0]);
        pg1_d = pg1_q + 32'(gnt[1]);
        pcf_d = pcf_q + 32'(conflict);
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pcf_q <= '0;
        end else begin
            pg0_q <= pg0_d;
            pg1_q <= pg1_d;
            pcf_q <= pcf_d;
        end
    end

    assign perf_grant0   = pg0_q;
    assign perf_grant1   = pg1_q;
    assign perf_conflict = pcf_q;
`endif
endmodule

// File: tb/tb_mul24_sched.sv
// tb_mul24_sched: scoreboard bench for mul24_sched with a
// behavioural 3-stage multiplier standing in for mul24.
module tb_mul24_sched;
    localparam int W = 24;
    localparam int DEPTH = 4;
    localparam int LAT = 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   m;
    } op_t;

    typedef struct {
        logic [2*W-1:0] p;
        int             st;
    } exp_t;

    logic           clk = 0;
    logic           rst = 1;
    logic [1:0]     req_valid = 0;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a = 0;
    logic [2*W-1:0] req_b = 0;
    logic [3:0]     req_mode = 0;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready = 0;
    logic [4*W-1:0] resp_data;
    logic           mul_valid;
    logic [1:0]     mul_mode;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_res_valid;
    logic [2*W-1:0] mul_res;
    logic           err;
`ifdef MUL24_SCHED_PERF_EN
    logic [31:0]    perf_grant0, perf_grant1, perf_conflict;
`endif

    mul24_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data),
        .mul_valid(mul_valid), .mul_mode(mul_mode),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_res_valid(mul_res_valid), .mul_res(mul_res),
        .err(err)
`ifdef MUL24_SCHED_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    // 00 uu, 01 ss, 11 su (a signed); 10 treated as uu
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
            input logic [W-1:0] b, input logic [1:0] m);
        logic [63:0] x, y, p;
        logic sa, sb;
        sa = (m == 2'b01) || (m == 2'b11);
        sb = (m == 2'b01);
        x = sa ? {{40{a[W-1]}}, a} : {40'b0, a};
        y = sb ? {{40{b[W-1]}}, b} : {40'b0, b};
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // behavioural multiplier: LAT register stages, no stall
    logic           sv [LAT];
    logic [2*W-1:0] sp [LAT];
    logic           inject = 0;
    initial for (int i = 0; i < LAT; i++) begin sv[i] = 0; sp[i] = 0; end
    always @(posedge clk) begin
        sv[0] <= mul_valid;
        sp[0] <= ref_mul(mul_a, mul_b, mul_mode);
        for (int i = 1; i < LAT; i++) begin
            sv[i] <= sv[i-1];
            sp[i] <= sp[i-1];
        end
        cyc <= cyc + 1;
    end
    assign mul_res_valid = sv[LAT-1] | inject;
    assign mul_res = sv[LAT-1] ? sp[LAT-1] : '0;

    op_t            op_q [2][$];
    exp_t           exp_q [2][$];
    logic [2*W-1:0] got_q [2][$];
    int             gnt_log [$];
    int             acc [2] = '{0, 0};
    logic [1:0]     en = 0;
    logic           rr_m = 0;
    logic           err_m = 0;

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = en[i] && (op_q[i].size() > 0);
            req_a[i*W +: W] = req_valid[i] ? op_q[i][0].a : '0;
            req_b[i*W +: W] = req_valid[i] ? op_q[i][0].b : '0;
            req_mode[i*2 +: 2] = req_valid[i] ? op_q[i][0].m : 2'b00;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        en = 0;
        op_q[0].delete();
        op_q[1].delete();
        drive();
        step(n);
        rst = 0;
        got_q[0].delete();
        got_q[1].delete();
        gnt_log.delete();
        drive();
    endtask

    task automatic add(input int p, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] m);
        op_t o;
        o.a = a; o.b = b; o.m = m;
        op_q[p].push_back(o);
    endtask

    // scoreboard: outstanding = accepted but not yet popped
    always @(negedge clk) begin
        logic [1:0] el, g;
        int p;
        exp_t e;
        logic rv;
        if (rst) begin
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_mul_valid", mul_valid, 1'b0);
            chk("rst_resp_valid", resp_valid, 2'b00);
            exp_q[0].delete();
            exp_q[1].delete();
            rr_m = 0;
            err_m = 0;
        end else begin
            chk("err", err, err_m);
            for (int i = 0; i < 2; i++)
                el[i] = req_valid[i] && (exp_q[i].size() < DEPTH);
            g = (el == 2'b11) ? (rr_m ? 2'b10 : 2'b01) : el;
            chk("req_ready", req_ready, g);
            chk("mul_valid", mul_valid, |g);
            if (g != 0) begin
                p = g[1] ? 1 : 0;
                chk("mul_a", mul_a, op_q[p][0].a);
                chk("mul_b", mul_b, op_q[p][0].b);
                chk("mul_mode", mul_mode,
                    (op_q[p][0].m == 2'b10) ? 2'b00 : op_q[p][0].m);
                if (op_q[p][0].m == 2'b10) err_m = 1;
                e.p = ref_mul(op_q[p][0].a, op_q[p][0].b, op_q[p][0].m);
                e.st = cyc + 1;
                exp_q[p].push_back(e);
                op_q[p].pop_front();
                acc[p]++;
                gnt_log.push_back(p);
                rr_m = ~g[1];
            end else begin
                chk("mul_a_idle", {mul_a, mul_b}, 48'h0);
            end
            for (int i = 0; i < 2; i++) begin
                rv = (exp_q[i].size() > 0) && (exp_q[i][0].st + LAT <= cyc);
                chk($sformatf("resp_valid%0d", i), resp_valid[i], rv);
                if (rv && resp_valid[i]) begin
                    chk($sformatf("resp_data%0d", i),
                        resp_data[i*2*W +: 2*W], exp_q[i][0].p);
                    if (resp_ready[i]) begin
                        got_q[i].push_back(resp_data[i*2*W +: 2*W]);
                        exp_q[i].pop_front();
                    end
                end
            end
            if (inject) err_m = 1;
        end
    end

    initial begin
        int b0, b1;
        do_reset(3);
        chk("reset_err", err, 1'b0);
        chk("reset_resp", resp_valid, 2'b00);

        // single op on port 0
        resp_ready = 2'b11;
        en = 2'b11;
        add(0, 24'd3, 24'd5, 2'b00);
        drive();
        step(10);
        chk("p0_cnt", got_q[0].size(), 1);
        if (got_q[0].size() > 0) chk("p0_15", got_q[0][0], 48'd15);
        chk("p1_none", got_q[1].size(), 0);

        // both ports saturating
        do_reset(1);
        resp_ready = 2'b11;
        en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            add(0, 24'(i + 1), 24'd10, 2'b00);
            add(1, 24'(100 + i), 24'd3, 2'b01);
        end
        drive();
        step(20);
        chk("alt_len", gnt_log.size(), 8);
        if (gnt_log.size() >= 4) begin
            chk("alt0", gnt_log[0], 0);
            chk("alt1", gnt_log[1], 1);
            chk("alt2", gnt_log[2], 0);
            chk("alt3", gnt_log[3], 1);
        end
        chk("alt_p0n", got_q[0].size(), 4);
        if (got_q[1].size() > 0) chk("alt_p1_300", got_q[1][0], 48'd300);

        // port 1 stalled by credit, port 0 unaffected
        do_reset(1);
        resp_ready = 2'b01;
        en = 2'b11;
        b0 = acc[0];
        b1 = acc[1];
        for (int i = 0; i < 8; i++) add(1, 24'(i + 7), 24'd11, 2'b00);
        for (int i = 0; i < 3; i++) add(0, 24'(i + 2), 24'd4, 2'b00);
        drive();
        step(20);
        chk("stall_p1_acc", acc[1] - b1, 4);
        chk("stall_p0_acc", acc[0] - b0, 3);
        chk("stall_blocked", {req_valid[1], req_ready[1]}, 2'b10);
        chk("stall_p0_got", got_q[0].size(), 3);
        resp_ready = 2'b11;
        step(30);
        chk("resume_p1_acc", acc[1] - b1, 8);
        chk("resume_p1_got", got_q[1].size(), 8);
        if (got_q[1].size() > 0) chk("resume_p1_77", got_q[1][0], 48'd77);

        // signed x signed
        do_reset(1);
        resp_ready = 2'b11;
        en = 2'b11;
        add(0, 24'hFFFFFF, 24'd2, 2'b01);
        drive();
        step(10);
        chk("ss_cnt", got_q[0].size(), 1);
        if (got_q[0].size() > 0) chk("ss_val", got_q[0][0], 48'hFFFFFFFFFFFE);
        chk("ss_err", err, 1'b0);

        // stray return with empty tag pipe
        inject = 1;
        step(1);
        inject = 0;
        step(5);
        chk("stray_err", err, 1'b1);
        chk("stray_nopush", got_q[0].size() + got_q[1].size(), 1);
        do_reset(1);
        chk("clr_err", err, 1'b0);
        chk("clr_resp", resp_valid, 2'b00);

        // reset with ops in flight
        resp_ready = 2'b11;
        en = 2'b01;
        b0 = acc[0];
        for (int i = 0; i < 3; i++) add(0, 24'(i + 5), 24'd6, 2'b00);
        drive();
        for (int t = 0; t < 10 && acc[0] < b0 + 3; t++) step(1);
        chk("mid_acc", acc[0] - b0, 3);
        do_reset(1);
        step(12);
        chk("mid_noresp", got_q[0].size(), 0);
        chk("mid_err", err, 1'b0);

        // illegal mode issues as uu and flags err
        en = 2'b11;
        add(1, 24'd7, 24'd9, 2'b10);
        drive();
        step(10);
        chk("ill_cnt", got_q[1].size(), 1);
        if (got_q[1].size() > 0) chk("ill_63", got_q[1][0], 48'd63);
        chk("ill_err", err, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
